alu_ctrl_seq: RTL and testbench

Parametrised successor to the EX-stage ALU control decoder. It decodes ALUOp/funct into select codes for the ALU, shifter, multiplier and result mux. It also sequences multi-cycle MULTU/DIVU operations with a down-counter FSM and raises a pipeline stall when a HI/LO hazard exists. It sits between the ID/EX register and the EX functional units.

---
 rtl/alu_ctrl_seq.sv | 156 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: combinational funct/ALUOp decode plus a down-counter
// sequencer for multi-cycle MULTU/DIVU with HI/LO hazard stall generation.
module alu_ctrl_seq #(
    parameter int FUNCT_W     = 6,
    parameter int CNT_W       = 7,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic               flush,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Signal,
    output logic [FUNCT_W-1:0] SignaltoALU,
    output logic [FUNCT_W-1:0] SignaltoSHT,
    output logic [FUNCT_W-1:0] SignaltoMULT,
    output logic [FUNCT_W-1:0] SignaltoMUX,
    output logic               stall,
    output logic               busy,
    output logic               mult_start,
    output logic               div_start,
    output logic               hilo_we,
    output logic               hilo_src,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [FUNCT_W-1:0] OP_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] OP_SUB   = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] OP_SLT   = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] OP_MULTU = FUNCT_W'(6'b011001);
    localparam logic [FUNCT_W-1:0] OP_DIVU  = FUNCT_W'(6'b011011);
    localparam logic [FUNCT_W-1:0] OP_MFHI  = FUNCT_W'(6'b010000);
    localparam logic [FUNCT_W-1:0] OP_MFLO  = FUNCT_W'(6'b010010);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    // Cycle counts are loaded as N-1, so N up to 2^CNT_W still fits the counter.
    if (FUNCT_W < 6) begin : g_bad_funct
        $error("alu_ctrl_seq: FUNCT_W must be at least 6");
    end
    if (MULT_CYCLES < 1 || MULT_CYCLES > (1 << CNT_W)) begin : g_bad_mult
        $error("alu_ctrl_seq: MULT_CYCLES outside 1..2^CNT_W");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > (1 << CNT_W)) begin : g_bad_div
        $error("alu_ctrl_seq: DIV_CYCLES outside 1..2^CNT_W");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               src_q, src_d;
    logic               mstart_q, mstart_d;
    logic               dstart_q, dstart_d;

    logic [FUNCT_W-1:0] code;
    logic               is_mdu;
    logic               hilo_op;
    logic               issue;

    always_comb begin
        code = Signal;
        unique case (ALUOp)
            2'b00:   code = OP_ADD;
            2'b01:   code = OP_SUB;
            2'b11:   code = OP_SLT;
            default: code = Signal;
        endcase
    end

    assign SignaltoALU  = code;
    assign SignaltoSHT  = code;
    assign SignaltoMULT = code;
    assign SignaltoMUX  = code;

    assign is_mdu  = (Signal == OP_MULTU) || (Signal == OP_DIVU);
    assign hilo_op = valid && (ALUOp == 2'b10) &&
                     (is_mdu || (Signal == OP_MFHI) || (Signal == OP_MFLO));
    assign issue   = hilo_op && is_mdu && (state_q == IDLE) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            src_q    <= 1'b0;
            mstart_q <= 1'b0;
            dstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            mstart_q <= mstart_d;
            dstart_q <= dstart_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        mstart_d = 1'b0;
        dstart_d = 1'b0;
        if (flush) begin
            // Abort wins over everything; hilo_src keeps the last issued source.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        if (Signal == OP_MULTU) begin
                            state_d  = MBUSY;
                            cnt_d    = MULT_LOAD;
                            src_d    = 1'b0;
                            mstart_d = 1'b1;
                        end else begin
                            state_d  = DBUSY;
                            cnt_d    = DIV_LOAD;
                            src_d    = 1'b1;
                            dstart_d = 1'b1;
                        end
                    end
                end
                MBUSY, DBUSY: begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign stall      = hilo_op && (state_q != IDLE);
    assign hilo_we    = (state_q == DONE);
    assign hilo_src   = src_q;
    assign mult_start = mstart_q;
    assign div_start  = dstart_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomised and directed checks of two alu_ctrl_seq instances (long and
// single-cycle multiply) against a timeline model of each in-flight operation.
module tb_alu_ctrl_seq;

    localparam int FW = 6;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR  = 6'b100101, F_SLT = 6'b101010, F_SLL = 6'b000000,
                           F_SRL = 6'b000010, F_MULTU = 6'b011001, F_DIVU = 6'b011011,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, flush;
    logic [1:0]    alu_op;
    logic [FW-1:0] sig;

    logic [FW-1:0] o_alu[2], o_sht[2], o_mult[2], o_mux[2];
    logic          o_stall[2], o_busy[2], o_ms[2], o_ds[2], o_we[2], o_src[2];
    logic [1:0]    o_dbg[2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: per instance, at most one operation issued at cycle t_iss lasting n_op busy cycles.
    int n_mult[2] = '{32, 1};
    int n_div[2]  = '{4, 3};
    bit act[2];
    int t_iss[2];
    int n_op[2];
    bit kind_div[2];
    bit src_m[2];
    int we_seen[2];
    int we_exp[2];

    always #5 clk = ~clk;

    alu_ctrl_seq #(.FUNCT_W(FW), .CNT_W(7), .MULT_CYCLES(32), .DIV_CYCLES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .ALUOp(alu_op), .Signal(sig),
        .SignaltoALU(o_alu[0]), .SignaltoSHT(o_sht[0]), .SignaltoMULT(o_mult[0]),
        .SignaltoMUX(o_mux[0]), .stall(o_stall[0]), .busy(o_busy[0]),
        .mult_start(o_ms[0]), .div_start(o_ds[0]), .hilo_we(o_we[0]), .hilo_src(o_src[0]),
        .dbg_state(o_dbg[0])
    );

    alu_ctrl_seq #(.FUNCT_W(FW), .CNT_W(7), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .ALUOp(alu_op), .Signal(sig),
        .SignaltoALU(o_alu[1]), .SignaltoSHT(o_sht[1]), .SignaltoMULT(o_mult[1]),
        .SignaltoMUX(o_mux[1]), .stall(o_stall[1]), .busy(o_busy[1]),
        .mult_start(o_ms[1]), .div_start(o_ds[1]), .hilo_we(o_we[1]), .hilo_src(o_src[1]),
        .dbg_state(o_dbg[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [5:0] exp_code(input logic [1:0] op, input logic [5:0] s);
        case (op)
            2'b00:   return F_ADD;
            2'b01:   return F_SUB;
            2'b11:   return F_SLT;
            default: return s;
        endcase
    endfunction

    function automatic bit is_hilo(input logic v, input logic [1:0] op, input logic [5:0] s);
        return v && op == 2'b10 && (s == F_MULTU || s == F_DIVU || s == F_MFHI || s == F_MFLO);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            act[i]   = 1'b0;
            src_m[i] = 1'b0;
        end
    endtask

    // Compare all outputs of both instances for the current cycle, then advance the model.
    task automatic check_cycle();
        bit hop, bsy, done_e, ms_e, ds_e;
        logic [5:0] ce;
        hop = is_hilo(valid, alu_op, sig);
        ce  = exp_code(alu_op, sig);
        for (int i = 0; i < 2; i++) begin
            if (act[i] && cyc > t_iss[i] + n_op[i] + 1) act[i] = 1'b0;
            bsy    = act[i];
            done_e = act[i] && cyc == t_iss[i] + n_op[i] + 1;
            ms_e   = act[i] && !kind_div[i] && cyc == t_iss[i] + 1;
            ds_e   = act[i] && kind_div[i] && cyc == t_iss[i] + 1;
            check($sformatf("alu%0d", i),   32'(o_alu[i]),   32'(ce));
            check($sformatf("sht%0d", i),   32'(o_sht[i]),   32'(ce));
            check($sformatf("mult%0d", i),  32'(o_mult[i]),  32'(ce));
            check($sformatf("mux%0d", i),   32'(o_mux[i]),   32'(ce));
            check($sformatf("stall%0d", i), 32'(o_stall[i]), 32'(hop && bsy));
            check($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(bsy));
            check($sformatf("mstart%0d", i), 32'(o_ms[i]),   32'(ms_e));
            check($sformatf("dstart%0d", i), 32'(o_ds[i]),   32'(ds_e));
            check($sformatf("hilo_we%0d", i), 32'(o_we[i]),  32'(done_e));
            check($sformatf("hilo_src%0d", i), 32'(o_src[i]), 32'(src_m[i]));
            if (o_we[i] === 1'b1) we_seen[i]++;
            if (done_e) we_exp[i]++;
            if (flush) begin
                act[i] = 1'b0;
            end else if (hop && (sig == F_MULTU || sig == F_DIVU) && !bsy) begin
                act[i]      = 1'b1;
                t_iss[i]    = cyc;
                kind_div[i] = (sig == F_DIVU);
                n_op[i]     = kind_div[i] ? n_div[i] : n_mult[i];
                src_m[i]    = kind_div[i];
            end
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [1:0] op, input logic [5:0] s);
        valid  = v;
        flush  = f;
        alu_op = op;
        sig    = s;
    endtask

    // Inputs are applied at the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        #1;
        check_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input logic v, input logic f, input logic [1:0] op, input logic [5:0] s,
                       input int n);
        for (int k = 0; k < n; k++) begin
            drive(v, f, op, s);
            step();
        end
    endtask

    // Reset asserted between edges: registered outputs must clear without a clock edge.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_busy%0d", i),   32'(o_busy[i]),  32'd0);
            check($sformatf("rst_stall%0d", i),  32'(o_stall[i]), 32'd0);
            check($sformatf("rst_mstart%0d", i), 32'(o_ms[i]),    32'd0);
            check($sformatf("rst_dstart%0d", i), 32'(o_ds[i]),    32'd0);
            check($sformatf("rst_we%0d", i),     32'(o_we[i]),    32'd0);
            check($sformatf("rst_src%0d", i),    32'(o_src[i]),   32'd0);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    logic [5:0] pick[11] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL,
                             F_MULTU, F_DIVU, F_MFHI, F_MFLO};

    initial begin
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            we_seen[i] = 0;
            we_exp[i]  = 0;
        end
        drive(1'b1, 1'b0, 2'b10, F_MULTU);
        @(negedge clk);
        pulse_reset();

        // Decode only, no HI/LO traffic.
        run(1'b1, 1'b0, 2'b00, F_AND, 1);
        run(1'b1, 1'b0, 2'b01, F_AND, 1);
        run(1'b1, 1'b0, 2'b11, F_AND, 1);
        run(1'b1, 1'b0, 2'b10, F_SRL, 1);

        // MULTU then ADD/OR traffic during MBUSY, then MULTU held across DONE.
        run(1'b1, 1'b0, 2'b10, F_MULTU, 1);
        for (int k = 0; k < 31; k++) run(1'b1, 1'b0, 2'b10, (k % 2) ? F_ADD : F_OR, 1);
        run(1'b1, 1'b0, 2'b10, F_MULTU, 4);
        run(1'b0, 1'b0, 2'b00, F_ADD, 36);

        // DIVU followed by a held MFLO.
        run(1'b1, 1'b0, 2'b10, F_DIVU, 1);
        run(1'b1, 1'b0, 2'b10, F_MFLO, 7);
        run(1'b0, 1'b0, 2'b00, F_ADD, 3);

        // Flush in the third DBUSY cycle.
        run(1'b1, 1'b0, 2'b10, F_DIVU, 1);
        run(1'b0, 1'b0, 2'b00, F_ADD, 2);
        run(1'b0, 1'b1, 2'b00, F_ADD, 1);
        run(1'b1, 1'b0, 2'b10, F_MFHI, 6);

        // Reset in the middle of MBUSY; nothing must be written afterwards.
        run(1'b1, 1'b0, 2'b10, F_MULTU, 1);
        run(1'b0, 1'b0, 2'b00, F_ADD, 5);
        pulse_reset();
        run(1'b1, 1'b0, 2'b10, F_MFLO, 40);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
                  ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : pick[$urandom_range(0, 10)]);
            step();
        end

        for (int i = 0; i < 2; i++)
            check($sformatf("we_count%0d", i), 32'(we_seen[i]), 32'(we_exp[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
